// File: rtl/wrr_hold_arbiter_pkg.sv
// Shared types and width helpers for the weighted round-robin hold arbiter.
// The interface, the picker and the top level all import this package.
package wrr_hold_arbiter_pkg;

  localparam int N_MIN = 2;
  localparam int N_MAX = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  // Owner index width; at least one bit even for degenerate sizes.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Hold counter width; MAX_HOLD = 0 (no timeout) still gets a 1-bit counter.
  function automatic int hold_width(input int max_hold);
    return (max_hold > 0) ? $clog2(max_hold + 1) : 1;
  endfunction

endpackage

// File: rtl/wrr_hold_arbiter_if.sv
// Request/grant bundle between the requesters and the arbiter.
// The requester side uses the master modport; the arbiter uses slave.
interface wrr_hold_arbiter_if #(
  parameter int N  = 4,
  parameter int WW = 4
);
  import wrr_hold_arbiter_pkg::*;

  localparam int IW = idx_width(N);

  logic [N-1:0]    req;
  logic            rel;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    gnt;
  logic            gnt_vld;
  logic [IW-1:0]   gnt_id;
  logic            timeout;

  modport master (
    output req, rel, weight,
    input  gnt, gnt_vld, gnt_id, timeout
  );

  modport slave (
    input  req, rel, weight,
    output gnt, gnt_vld, gnt_id, timeout
  );

endinterface

// File: rtl/wrr_hold_arbiter_rr_pick_first.sv
// Combinational rotating-priority picker: first set bit of cand searching
// upward from last+1, wrapping modulo N. Reusable by other arbiters.
module rr_pick_first #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  cand,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          found
);

  int pos;

  always_comb begin
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    pos    = 0;
    // Offset N revisits 'last' itself, so it has lowest priority.
    for (int k = 1; k <= N; k++) begin
      pos = (int'(last) + k) % N;
      if (!found && cand[pos]) begin
        found       = 1'b1;
        onehot[pos] = 1'b1;
        idx         = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/wrr_hold_arbiter.sv
// Weighted round-robin arbiter with grant locking: a winner keeps the
// resource until release, request drop, or the optional MAX_HOLD timeout.
module wrr_hold_arbiter
  import wrr_hold_arbiter_pkg::*;
#(
  parameter int N        = 4,
  parameter int WW       = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  wrr_hold_arbiter_if.slave bus
);

  localparam int IW = idx_width(N);
  localparam int HW = hold_width(MAX_HOLD);

  arb_state_e    state_reg, state_next;
  logic [N-1:0]  gnt_reg, gnt_next;
  logic          gnt_vld_reg;
  logic [IW-1:0] gnt_id_reg, gnt_id_next;
  logic [IW-1:0] last_reg, last_next;
  logic          timeout_reg, timeout_next;
  logic [HW-1:0] hold_reg, hold_next;

  logic [N-1:0]  credit_nz;
  logic [N-1:0]  elig;
  logic [N-1:0]  cand;
  logic [N-1:0]  pick_onehot;
  logic [IW-1:0] pick_idx;
  logic          pick_found;
  logic          reload;
  logic          grant_fire;
  logic          owner_req;
  logic          hold_expired;
  logic          release_now;

  // Eligible requesters still hold credit; once all requesting ones are
  // exhausted, every credit reloads and the plain request vector competes.
  assign elig       = bus.req & credit_nz;
  assign reload     = (state_reg == ST_IDLE) && (elig == '0) && (bus.req != '0);
  assign cand       = reload ? bus.req : elig;
  assign grant_fire = (state_reg == ST_IDLE) && pick_found;

  rr_pick_first #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .cand   (cand),
    .last   (last_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_credit
      logic [WW-1:0] weight_i;
      logic [WW-1:0] reload_val;
      logic [WW-1:0] credit_reg;
      logic [WW-1:0] credit_next;

      assign weight_i   = bus.weight[gi*WW +: WW];
      // A zero weight still earns one grant per reload round.
      assign reload_val = (weight_i == '0) ? WW'(1) : weight_i;

      always_comb begin
        credit_next = credit_reg;
        if (reload) begin
          credit_next = reload_val;
        end
        if (grant_fire && pick_onehot[gi]) begin
          credit_next = credit_next - WW'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          credit_reg <= '0;
        end else begin
          credit_reg <= credit_next;
        end
      end

      assign credit_nz[gi] = |credit_reg;
    end

    if (MAX_HOLD != 0) begin : g_timeout
      assign hold_expired = (hold_reg == HW'(MAX_HOLD));
    end else begin : g_no_timeout
      assign hold_expired = 1'b0;
    end
  endgenerate

  assign owner_req   = bus.req[gnt_id_reg];
  assign release_now = bus.rel | ~owner_req | hold_expired;

  always_comb begin
    state_next   = state_reg;
    gnt_next     = gnt_reg;
    gnt_id_next  = gnt_id_reg;
    last_next    = last_reg;
    hold_next    = hold_reg;
    timeout_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        gnt_next = '0;
        if (pick_found) begin
          state_next  = ST_BUSY;
          gnt_next    = pick_onehot;
          gnt_id_next = pick_idx;
          last_next   = pick_idx;
          hold_next   = HW'(1);
        end
      end
      ST_BUSY: begin
        if (release_now) begin
          state_next   = ST_GAP;
          gnt_next     = '0;
          // Only a genuine force-release counts; a voluntary exit in the
          // same cycle as expiry does not pulse timeout.
          timeout_next = hold_expired & ~bus.rel & owner_req;
        end else if (hold_reg != '1) begin
          hold_next = hold_reg + HW'(1);
        end
      end
      ST_GAP: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
      end
      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      gnt_reg     <= '0;
      gnt_vld_reg <= 1'b0;
      gnt_id_reg  <= '0;
      last_reg    <= IW'(N - 1);
      hold_reg    <= '0;
      timeout_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      gnt_reg     <= gnt_next;
      gnt_vld_reg <= |gnt_next;
      gnt_id_reg  <= gnt_id_next;
      last_reg    <= last_next;
      hold_reg    <= hold_next;
      timeout_reg <= timeout_next;
    end
  end

  assign bus.gnt     = gnt_reg;
  assign bus.gnt_vld = gnt_vld_reg;
  assign bus.gnt_id  = gnt_id_reg;
  assign bus.timeout = timeout_reg;

endmodule

// File: tb/tb_wrr_hold_arbiter.sv
// Directed bench for wrr_hold_arbiter: cycle vectors from a table plus
// hand-written sequences for hold timeout and asynchronous reset.
module tb_wrr_hold_arbiter;

  localparam int N        = 4;
  localparam int WW       = 4;
  localparam int MAX_HOLD = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  wrr_hold_arbiter_if #(.N(N), .WW(WW)) bus ();

  wrr_hold_arbiter #(
    .N        (N),
    .WW       (WW),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    bit              do_rst;
    logic [N-1:0]    req;
    logic            rel;
    logic [N*WW-1:0] weight;
    logic [N-1:0]    exp_gnt;
    logic [1:0]      exp_id;
    logic            exp_to;
    string           name;
  } vec_t;

  vec_t vecs[$];
  int   tests  = 0;
  int   failed = 0;

  function automatic void add_row(bit r, logic [N-1:0] rq, logic rl, logic [N*WW-1:0] w,
                                  logic [N-1:0] g, logic [1:0] id, logic to, string nm);
    vec_t v;
    v.do_rst = r; v.req = rq; v.rel = rl; v.weight = w;
    v.exp_gnt = g; v.exp_id = id; v.exp_to = to; v.name = nm;
    vecs.push_back(v);
  endfunction

  // One immediately released grant: grant cycle, GAP cycle, IDLE cycle.
  function automatic void add_grant(bit r, logic [N-1:0] rq, logic [N*WW-1:0] w,
                                    int id, string nm);
    logic [N-1:0] g;
    g = '0;
    g[id] = 1'b1;
    add_row(r, rq, 1'b1, w, g, 2'(id), 1'b0, nm);
    add_row(1'b0, rq, 1'b1, w, '0, 2'(id), 1'b0, {nm, "_gap"});
    add_row(1'b0, rq, 1'b1, w, '0, 2'(id), 1'b0, {nm, "_idle"});
  endfunction

  task automatic check(input string nm, input logic [N-1:0] g, input logic [1:0] id,
                       input logic to);
    logic v;
    v = |g;
    tests++;
    if (bus.gnt !== g || bus.gnt_vld !== v || bus.gnt_id !== id || bus.timeout !== to) begin
      failed++;
      $display("[TB] FAIL %s: got gnt=%b vld=%b id=%0d to=%b, want gnt=%b vld=%b id=%0d to=%b",
               nm, bus.gnt, bus.gnt_vld, bus.gnt_id, bus.timeout, g, v, id, to);
    end else begin
      $display("[TB] ok   %s: gnt=%b vld=%b id=%0d to=%b", nm, bus.gnt, bus.gnt_vld,
               bus.gnt_id, bus.timeout);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    bus.req = '0;
    bus.rel = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int seq0[5]  = '{0, 1, 2, 3, 0};
  int seq1[12] = '{0, 1, 2, 3, 0, 0, 1, 2, 3, 0, 0, 0};
  int hold_cnt;
  int hold_exp;

  initial begin
    bus.req    = '0;
    bus.rel    = 1'b0;
    bus.weight = 16'h1111;

    // Equal weights, all requesting, immediate release.
    foreach (seq0[i]) add_grant(i == 0, 4'b1111, 16'h1111, seq0[i], $sformatf("eq_g%0d", i));
    // Requester 0 has weight 3.
    foreach (seq1[i]) add_grant(i == 0, 4'b1111, 16'h1113, seq1[i], $sformatf("w3_g%0d", i));
    // Zero weight on requester 1 behaves as weight 1.
    add_grant(1'b1, 4'b0010, 16'h1101, 1, "w0_g0");
    add_grant(1'b0, 4'b0010, 16'h1101, 1, "w0_g1");
    // Owner drops its request without rel: no timeout pulse.
    add_row(1'b1, 4'b0001, 1'b0, 16'h1111, 4'b0001, 2'd0, 1'b0, "drop_grant");
    add_row(1'b0, 4'b0001, 1'b0, 16'h1111, 4'b0001, 2'd0, 1'b0, "drop_hold");
    add_row(1'b0, 4'b0000, 1'b0, 16'h1111, 4'b0000, 2'd0, 1'b0, "drop_gap");
    add_row(1'b0, 4'b0000, 1'b0, 16'h1111, 4'b0000, 2'd0, 1'b0, "drop_idle");

    do_reset();
    check("reset_state", 4'b0000, 2'd0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].do_rst) begin
        bus.weight = vecs[i].weight;
        do_reset();
      end
      bus.req    = vecs[i].req;
      bus.rel    = vecs[i].rel;
      bus.weight = vecs[i].weight;
      step();
      check(vecs[i].name, vecs[i].exp_gnt, vecs[i].exp_id, vecs[i].exp_to);
    end

    // MAX_HOLD expiry: single held request, no release.
    bus.weight = 16'h1111;
    do_reset();
    bus.req  = 4'b0100;
    bus.rel  = 1'b0;
    hold_cnt = 0;
    for (int c = 0; c < 3 * MAX_HOLD; c++) begin
      step();
      if (bus.gnt == 4'b0100) hold_cnt++;
      else if (hold_cnt > 0) break;
    end
    hold_exp = MAX_HOLD;
    tests++;
    if (hold_cnt != hold_exp) begin
      failed++;
      $display("[TB] FAIL hold_len: got %0d cycles, want %0d", hold_cnt, hold_exp);
    end else begin
      $display("[TB] ok   hold_len: %0d cycles", hold_cnt);
    end
    check("hold_timeout_pulse", 4'b0000, 2'd2, 1'b1);
    step();
    check("hold_after_gap", 4'b0000, 2'd2, 1'b0);
    step();
    check("hold_regrant", 4'b0100, 2'd2, 1'b0);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    bus.req = 4'b1111;
    bus.rel = 1'b0;
    step();
    check("mid_grant", 4'b0001, 2'd0, 1'b0);
    step();
    check("mid_grant_held", 4'b0001, 2'd0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_drop", 4'b0000, 2'd0, 1'b0);
    step();
    rst_n   = 1'b1;
    bus.req = 4'b1010;
    bus.rel = 1'b1;
    step();
    check("post_reset_first", 4'b0010, 2'd1, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/wrr_hold_arbiter.md
# wrr_hold_arbiter

Weighted round-robin arbiter with grant locking for a shared single-owner resource (bus port, memory bank, DMA channel) among N requesters. It complements the team's plain 4-way round-robin arbiter for cases where a winner must keep the resource for a multi-cycle transaction and where requesters need unequal bandwidth shares. It sits between the requesters and the resource mux, driving the one-hot select and owner index.

## Interface
- N, 4, number of requesters (2..16)
- WW, 4, weight/credit width per requester
- MAX_HOLD, 16, max cycles a grant may be held; 0 disables timeout
- clk  in  1  clock
- rst_n  in  1  reset rst_n, asynchronous, active-low; clock clk
- req  in  N  request per requester, level; must stay high until granted or abandoned
- rel  in  1  release from current owner; ignored when no grant is active
- weight  in  N*WW  per-requester weight, slice i = weight[i*WW +: WW]; quasi-static
- gnt  out  N  one-hot registered grant, all-zero when idle
- gnt_vld  out  1  OR of gnt, registered
- gnt_id  out  $clog2(N)  index of current owner; holds last owner when idle
- timeout  out  1  one-cycle pulse when a grant is force-released by MAX_HOLD

## Operation
- States: IDLE (no owner, arbitrate every cycle), BUSY (grant held), GAP (one turnaround cycle, gnt=0, no arbitration).
- IDLE: eligible set E = req & (credit != 0). If E empty but req non-zero: reload all credits from weight (weight 0 treated as 1) and arbitrate over req in the same cycle. Winner = first set bit of the candidate set searching upward from last+1, wrapping mod N. Winner's credit decrements by 1 (post-reload value if reload happened). Next state BUSY.
- BUSY exits to GAP when any of: rel=1; req[owner]=0; hold count reaches MAX_HOLD (MAX_HOLD≠0). Precedence irrelevant to outcome; timeout pulses only if rel=0 and req[owner]=1 at the expiry cycle.
- GAP always goes to IDLE next cycle.
- Hold counter: loads 1 on entry to BUSY, increments each BUSY cycle, saturates; width $clog2(MAX_HOLD+1).
- last pointer updates to winner at grant; credits change only at grant or reload.
- Weight changes take effect at the next reload only.
- Requests arriving during BUSY/GAP are not latched; they are evaluated in IDLE.

## Timing
- Reset: state IDLE, gnt=0, gnt_vld=0, gnt_id=0, timeout=0, last=N-1 (requester 0 first), all credits=0 (first arbitration triggers reload).
- req sampled in IDLE cycle T -> gnt/gnt_vld/gnt_id valid at T+1.
- Release condition at BUSY cycle T -> gnt=0 at T+1 (GAP) -> IDLE at T+2 -> next grant earliest T+3. timeout high at T+1 only.
- Grant duration with MAX_HOLD=M and no release: exactly M cycles.
- Reset mid-grant: outputs drop asynchronously; credits and pointer return to reset values.

## Structure
- Shared package: state encoding enum (IDLE/BUSY/GAP), clog2-based width constants.
- One sub-module: rr_pick_first — combinational rotating priority picker (N-bit candidate, last pointer -> one-hot + index, found flag); reusable by other arbiters.
- Credits: N registers of WW bits; no other storage.

## Test plan
- N=4, weights all 1, req=4'b1111 held, each owner asserts rel on its first BUSY cycle -> grant order 0,1,2,3,0 with gnt rising every 3 cycles.
- Weights {3,1,1,1} (req0 weight 3), all requesting, rel immediate -> per 6-grant window: 0,1,2,3,0,0 pattern counts req0=3, others=1 each.
- MAX_HOLD=16, single req2 held, rel=0 -> gnt=4'b0100 for exactly 16 cycles, timeout pulse in GAP cycle, regrant to 2 two cycles later.
- Owner drops req while rel=0 -> gnt clears next cycle, timeout stays 0.
- Weight 0 on req1, only req1 requesting -> reload treats weight as 1, req1 granted next cycle.
- rst_n asserted during BUSY -> gnt=0 immediately; after release, req=4'b1010 -> req1 granted first.
